// File: rtl/sensor_packet_builder.sv
// Packet assembler: latches per-channel quaternion/gyro reports into shadow registers,
// snapshots them on pkt_start and streams a framed, checksummed byte packet over valid/ready.
module sensor_packet_builder #(
    parameter int          NUM_SENSORS = 2,
    parameter logic [7:0]  HEADER_BYTE = 8'hAA
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SENSORS-1:0]    quat_valid,
    input  logic [64*NUM_SENSORS-1:0] quat_data,
    input  logic [NUM_SENSORS-1:0]    gyro_valid,
    input  logic [48*NUM_SENSORS-1:0] gyro_data,
    input  logic [NUM_SENSORS-1:0]    sensor_ok,
    input  logic                      pkt_start,
    input  logic                      pkt_abort,
    output logic [7:0]                out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic                      pkt_busy,
    output logic                      start_drop
);

    // state    | meaning
    // S_IDLE   | waiting for pkt_start
    // S_SNAP   | one cycle: copy shadows and flags into the snapshot
    // S_STREAM | presenting snapshot bytes on out_data until the checksum byte is taken
    typedef enum logic [1:0] {S_IDLE, S_SNAP, S_STREAM} state_t;

    localparam int PKT_LEN = 15*NUM_SENSORS + 3;
    localparam int IW      = $clog2(PKT_LEN + 1);

    state_t state_q, state_d;

    logic [63:0] quat_sh_q [NUM_SENSORS];
    logic [63:0] quat_sh_d [NUM_SENSORS];
    logic [47:0] gyro_sh_q [NUM_SENSORS];
    logic [47:0] gyro_sh_d [NUM_SENSORS];
    logic [63:0] snap_quat_q [NUM_SENSORS];
    logic [63:0] snap_quat_d [NUM_SENSORS];
    logic [47:0] snap_gyro_q [NUM_SENSORS];
    logic [47:0] snap_gyro_d [NUM_SENSORS];
    logic [7:0]  snap_flags_q [NUM_SENSORS];
    logic [7:0]  snap_flags_d [NUM_SENSORS];

    logic [NUM_SENSORS-1:0] quat_new_q, quat_new_d;
    logic [NUM_SENSORS-1:0] gyro_new_q, gyro_new_d;
    logic [IW-1:0]          byte_idx_q, byte_idx_d;
    logic [7:0]             csum_q, csum_d;
    logic [7:0]             seq_q, seq_d;
    logic                   start_drop_q, start_drop_d;

    logic [7:0]   pkt_byte;
    logic [119:0] rec;
    logic         is_last;

    assign is_last = (int'(byte_idx_q) == PKT_LEN - 1);

    // Byte mux: each channel record is {quat, gyro, flags}, sent MSB first.
    always_comb begin
        pkt_byte = 8'h00;
        rec      = '0;
        if (int'(byte_idx_q) == 0) begin
            pkt_byte = HEADER_BYTE;
        end else if (int'(byte_idx_q) == PKT_LEN - 2) begin
            pkt_byte = seq_q;
        end else if (is_last) begin
            pkt_byte = csum_q;
        end else begin
            for (int i = 0; i < NUM_SENSORS; i++) begin
                if (int'(byte_idx_q) >= 1 + 15*i && int'(byte_idx_q) < 16 + 15*i) begin
                    rec      = {snap_quat_q[i], snap_gyro_q[i], snap_flags_q[i]};
                    pkt_byte = 8'(rec >> (8*(15 + 15*i - int'(byte_idx_q))));
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            quat_sh_q    <= '{default: '0};
            gyro_sh_q    <= '{default: '0};
            snap_quat_q  <= '{default: '0};
            snap_gyro_q  <= '{default: '0};
            snap_flags_q <= '{default: '0};
            quat_new_q   <= '0;
            gyro_new_q   <= '0;
            byte_idx_q   <= '0;
            csum_q       <= '0;
            seq_q        <= '0;
            start_drop_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            quat_sh_q    <= quat_sh_d;
            gyro_sh_q    <= gyro_sh_d;
            snap_quat_q  <= snap_quat_d;
            snap_gyro_q  <= snap_gyro_d;
            snap_flags_q <= snap_flags_d;
            quat_new_q   <= quat_new_d;
            gyro_new_q   <= gyro_new_d;
            byte_idx_q   <= byte_idx_d;
            csum_q       <= csum_d;
            seq_q        <= seq_d;
            start_drop_q <= start_drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (pkt_start && !pkt_abort) state_d = S_SNAP;
            S_SNAP:   state_d = pkt_abort ? S_IDLE : S_STREAM;
            S_STREAM: if (pkt_abort || (out_ready && is_last)) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        quat_sh_d    = quat_sh_q;
        gyro_sh_d    = gyro_sh_q;
        snap_quat_d  = snap_quat_q;
        snap_gyro_d  = snap_gyro_q;
        snap_flags_d = snap_flags_q;
        byte_idx_d   = byte_idx_q;
        csum_d       = csum_q;
        seq_d        = seq_q;
        start_drop_d = pkt_start && (state_q != S_IDLE);

        // A strobe landing in the snapshot cycle survives the clear and counts toward the next packet.
        quat_new_d = quat_valid | ((state_q == S_SNAP) ? '0 : quat_new_q);
        gyro_new_d = gyro_valid | ((state_q == S_SNAP) ? '0 : gyro_new_q);

        for (int i = 0; i < NUM_SENSORS; i++) begin
            if (quat_valid[i]) quat_sh_d[i] = quat_data[64*i +: 64];
            if (gyro_valid[i]) gyro_sh_d[i] = gyro_data[48*i +: 48];
        end

        if (state_q == S_SNAP) begin
            for (int i = 0; i < NUM_SENSORS; i++) begin
                snap_quat_d[i]  = quat_sh_q[i];
                snap_gyro_d[i]  = gyro_sh_q[i];
                snap_flags_d[i] = {5'b0, sensor_ok[i], gyro_new_q[i], quat_new_q[i]};
            end
            byte_idx_d = '0;
            csum_d     = '0;
        end else if (state_q == S_STREAM && out_ready && !pkt_abort) begin
            csum_d     = csum_q + pkt_byte;
            byte_idx_d = byte_idx_q + IW'(1);
            if (is_last) seq_d = seq_q + 8'd1;
        end
    end

    always_comb begin
        out_valid  = (state_q == S_STREAM);
        out_last   = (state_q == S_STREAM) && is_last;
        out_data   = (state_q == S_STREAM) ? pkt_byte : 8'h00;
        pkt_busy   = (state_q != S_IDLE);
        start_drop = start_drop_q;
    end

endmodule

// File: tb/tb_sensor_packet_builder.sv
// Scoreboard bench for sensor_packet_builder: a packet model pushes expected bytes on pkt_start,
// a negedge monitor pops and compares them on every handshake.
module tb_sensor_packet_builder;

    localparam int         N       = 2;
    localparam int         PKT_LEN = 15*N + 3;
    localparam logic [7:0] HDR     = 8'hAA;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    quat_valid;
    logic [64*N-1:0] quat_data;
    logic [N-1:0]    gyro_valid;
    logic [48*N-1:0] gyro_data;
    logic [N-1:0]    sensor_ok;
    logic            pkt_start;
    logic            pkt_abort;
    logic [7:0]      out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic            pkt_busy;
    logic            start_drop;

    always #5 clk = ~clk;

    sensor_packet_builder #(.NUM_SENSORS(N), .HEADER_BYTE(HDR)) dut (
        .clk(clk), .rst_n(rst_n),
        .quat_valid(quat_valid), .quat_data(quat_data),
        .gyro_valid(gyro_valid), .gyro_data(gyro_data),
        .sensor_ok(sensor_ok), .pkt_start(pkt_start), .pkt_abort(pkt_abort),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .pkt_busy(pkt_busy), .start_drop(start_drop)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    logic [63:0] m_quat [N];
    logic [47:0] m_gyro [N];
    logic [N-1:0] m_qnew, m_gnew;
    logic [7:0]  m_seq;
    logic [7:0]  obs_pkt [0:127];
    int          obs_cnt = 0;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected idx=%0d got=%02h expected=none", obs_cnt, out_data);
            end else begin
                mon_e = sb.pop_front();
                if (out_data !== mon_e.data || out_last !== mon_e.last) begin
                    failures++;
                    $display("FAIL sb_byte idx=%0d got=%02h last=%0b expected=%02h last=%0b",
                             obs_cnt, out_data, out_last, mon_e.data, mon_e.last);
                end
            end
            if (obs_cnt < 128) obs_pkt[obs_cnt] = out_data;
            obs_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; quat_valid = '0; gyro_valid = '0; quat_data = '0; gyro_data = '0;
        pkt_start = 1'b0; pkt_abort = 1'b0; out_ready = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            m_quat[i] = '0;
            m_gyro[i] = '0;
        end
        m_qnew = '0; m_gnew = '0; m_seq = 8'h00;
        sb.delete();
        step();
    endtask

    task automatic send_quat(input int ch, input logic [63:0] v);
        quat_data[64*ch +: 64] = v;
        quat_valid[ch] = 1'b1;
        step();
        quat_valid = '0;
        m_quat[ch] = v;
        m_qnew[ch] = 1'b1;
    endtask

    task automatic send_gyro(input int ch, input logic [47:0] v);
        gyro_data[48*ch +: 48] = v;
        gyro_valid[ch] = 1'b1;
        step();
        gyro_valid = '0;
        m_gyro[ch] = v;
        m_gnew[ch] = 1'b1;
    endtask

    function automatic void push_expected();
        logic [7:0] b[$];
        logic [7:0] sum;
        exp_t       e;
        b.push_back(HDR);
        for (int ch = 0; ch < N; ch++) begin
            for (int k = 0; k < 8; k++) b.push_back(8'(m_quat[ch] >> (56 - 8*k)));
            for (int k = 0; k < 6; k++) b.push_back(8'(m_gyro[ch] >> (40 - 8*k)));
            b.push_back({5'b0, sensor_ok[ch], m_gnew[ch], m_qnew[ch]});
        end
        b.push_back(m_seq);
        sum = 8'h00;
        foreach (b[i]) sum += b[i];
        b.push_back(sum);
        foreach (b[i]) begin
            e.data = b[i];
            e.last = (i == b.size() - 1);
            sb.push_back(e);
        end
        m_qnew = '0;
        m_gnew = '0;
    endfunction

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || pkt_busy) && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (n >= 200) begin
            failures++;
            $display("FAIL drain_timeout remaining=%0d expected=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run_packet();
        obs_cnt = 0;
        push_expected();
        m_seq++;
        pkt_start = 1'b1;
        step();
        pkt_start = 1'b0;
        wait_drain();
    endtask

    task automatic test_reset();
        do_reset();
        checks += 5;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0b expected=0", out_valid); end
        if (out_last !== 1'b0) begin failures++; $display("FAIL rst_out_last got=%0b expected=0", out_last); end
        if (out_data !== 8'h00) begin failures++; $display("FAIL rst_out_data got=%02h expected=00", out_data); end
        if (pkt_busy !== 1'b0) begin failures++; $display("FAIL rst_pkt_busy got=%0b expected=0", pkt_busy); end
        if (start_drop !== 1'b0) begin failures++; $display("FAIL rst_start_drop got=%0b expected=0", start_drop); end
    endtask

    task automatic test_basic();
        logic [7:0] s;
        do_reset();
        sensor_ok = 2'b11;
        send_quat(0, {16'h4000, 16'h3000, 16'h2000, 16'h1000});
        send_quat(1, {16'h8000, 16'h0000, 16'h0000, 16'h0000});
        send_gyro(0, {16'h1111, 16'h2222, 16'h3333});
        obs_cnt = 0;
        push_expected();
        m_seq++;
        pkt_start = 1'b1;
        step();
        pkt_start = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || pkt_busy !== 1'b1) begin
            failures++; $display("FAIL snap_cycle got valid=%0b busy=%0b expected valid=0 busy=1", out_valid, pkt_busy);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== HDR) begin
            failures++; $display("FAIL latency_t2 got valid=%0b data=%02h expected valid=1 data=aa", out_valid, out_data);
        end
        wait_drain();
        s = 8'h00;
        for (int i = 0; i < PKT_LEN - 1; i++) s += obs_pkt[i];
        checks += 7;
        if (obs_cnt != PKT_LEN) begin failures++; $display("FAIL basic_len got=%0d expected=%0d", obs_cnt, PKT_LEN); end
        if (obs_pkt[1] !== 8'h40) begin failures++; $display("FAIL basic_b1 got=%02h expected=40", obs_pkt[1]); end
        if (obs_pkt[2] !== 8'h00) begin failures++; $display("FAIL basic_b2 got=%02h expected=00", obs_pkt[2]); end
        if (obs_pkt[16] !== 8'h80) begin failures++; $display("FAIL basic_b16 got=%02h expected=80", obs_pkt[16]); end
        if (obs_pkt[17] !== 8'h00) begin failures++; $display("FAIL basic_b17 got=%02h expected=00", obs_pkt[17]); end
        if (obs_pkt[31] !== 8'h00) begin failures++; $display("FAIL basic_seq got=%02h expected=00", obs_pkt[31]); end
        if (obs_pkt[32] !== s) begin failures++; $display("FAIL basic_csum got=%02h expected=%02h", obs_pkt[32], s); end
    endtask

    task automatic test_empty();
        int nz = 0;
        do_reset();
        sensor_ok = 2'b01;
        run_packet();
        for (int i = 1; i < 31; i++) if (i != 15 && obs_pkt[i] != 8'h00) nz++;
        checks += 5;
        if (obs_pkt[0] !== HDR) begin failures++; $display("FAIL empty_hdr got=%02h expected=aa", obs_pkt[0]); end
        if (nz != 0) begin failures++; $display("FAIL empty_data nonzero=%0d expected=0", nz); end
        if (obs_pkt[15] !== 8'h04) begin failures++; $display("FAIL empty_flags0 got=%02h expected=04", obs_pkt[15]); end
        if (obs_pkt[30] !== 8'h00) begin failures++; $display("FAIL empty_flags1 got=%02h expected=00", obs_pkt[30]); end
        if (obs_pkt[31] !== 8'h00) begin failures++; $display("FAIL empty_seq got=%02h expected=00", obs_pkt[31]); end
    endtask

    task automatic test_stall();
        int         n = 0;
        logic       have_prev = 1'b0;
        logic [7:0] prev_d = 8'h00;
        logic       prev_l = 1'b0;
        sensor_ok = 2'b11;
        send_quat(1, 64'h0123_4567_89AB_CDEF);
        send_gyro(1, 48'hFEDC_BA98_7654);
        obs_cnt = 0;
        push_expected();
        m_seq++;
        pkt_start = 1'b1;
        step();
        pkt_start = 1'b0;
        while ((sb.size() != 0 || pkt_busy) && n < 300) begin
            out_ready = ~out_ready;
            @(negedge clk);
            if (have_prev && out_valid) begin
                checks++;
                if (out_data !== prev_d || out_last !== prev_l) begin
                    failures++;
                    $display("FAIL stall_hold got=%02h/%0b expected=%02h/%0b", out_data, out_last, prev_d, prev_l);
                end
            end
            have_prev = out_valid && !out_ready;
            prev_d = out_data;
            prev_l = out_last;
            step();
            n++;
        end
        out_ready = 1'b1;
        checks++;
        if (n >= 300 || obs_cnt != PKT_LEN) begin
            failures++; $display("FAIL stall_len got=%0d expected=%0d", obs_cnt, PKT_LEN);
            sb.delete();
        end
    endtask

    task automatic test_drop_and_seq();
        obs_cnt = 0;
        push_expected();
        m_seq++;
        pkt_start = 1'b1;
        step();
        pkt_start = 1'b0;
        repeat (4) step();
        pkt_start = 1'b1;
        step();
        pkt_start = 1'b0;
        checks++;
        if (start_drop !== 1'b1) begin failures++; $display("FAIL drop_pulse got=%0b expected=1", start_drop); end
        step();
        checks++;
        if (start_drop !== 1'b0 || pkt_busy !== 1'b1) begin
            failures++; $display("FAIL drop_after got drop=%0b busy=%0b expected drop=0 busy=1", start_drop, pkt_busy);
        end
        wait_drain();
        checks++;
        if (obs_cnt != PKT_LEN) begin failures++; $display("FAIL drop_len got=%0d expected=%0d", obs_cnt, PKT_LEN); end

        do_reset();
        for (int p = 0; p < 3; p++) begin
            run_packet();
            checks++;
            if (obs_pkt[31] !== 8'(p)) begin failures++; $display("FAIL seq_%0d got=%02h expected=%02h", p, obs_pkt[31], 8'(p)); end
        end
        while (m_seq != 8'hFF) run_packet();
        run_packet();
        checks++;
        if (obs_pkt[31] !== 8'hFF) begin failures++; $display("FAIL seq_ff got=%02h expected=ff", obs_pkt[31]); end
        run_packet();
        checks++;
        if (obs_pkt[31] !== 8'h00) begin failures++; $display("FAIL seq_wrap got=%02h expected=00", obs_pkt[31]); end
    endtask

    task automatic test_snap_collision();
        sensor_ok = 2'b11;
        send_quat(1, {16'h1234, 48'h0});
        run_packet();
        obs_cnt = 0;
        push_expected();
        m_seq++;
        pkt_start = 1'b1;
        step();
        pkt_start = 1'b0;
        checks++;
        if (pkt_busy !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL coll_in_snap got busy=%0b valid=%0b expected busy=1 valid=0", pkt_busy, out_valid);
        end
        quat_data[127:64] = {16'h5678, 48'h0};
        quat_valid[1] = 1'b1;
        step();
        quat_valid = '0;
        m_quat[1] = {16'h5678, 48'h0};
        m_qnew[1] = 1'b1;
        wait_drain();
        checks += 2;
        if (obs_pkt[16] !== 8'h12) begin failures++; $display("FAIL coll_old_val got=%02h expected=12", obs_pkt[16]); end
        if (obs_pkt[30][0] !== 1'b0) begin failures++; $display("FAIL coll_old_flag got=%0b expected=0", obs_pkt[30][0]); end
        run_packet();
        checks += 2;
        if (obs_pkt[16] !== 8'h56) begin failures++; $display("FAIL coll_new_val got=%02h expected=56", obs_pkt[16]); end
        if (obs_pkt[30][0] !== 1'b1) begin failures++; $display("FAIL coll_new_flag got=%0b expected=1", obs_pkt[30][0]); end
    endtask

    task automatic test_abort();
        int n = 0;
        pkt_start = 1'b1;
        pkt_abort = 1'b1;
        step();
        pkt_start = 1'b0;
        pkt_abort = 1'b0;
        checks++;
        if (pkt_busy !== 1'b0) begin failures++; $display("FAIL abort_idle_start got busy=%0b expected=0", pkt_busy); end

        send_gyro(0, 48'hAAAA_5555_0F0F);
        obs_cnt = 0;
        push_expected();
        pkt_start = 1'b1;
        step();
        pkt_start = 1'b0;
        while (obs_cnt < 6 && n < 50) begin
            step();
            n++;
        end
        pkt_abort = 1'b1;
        out_ready = 1'b0;
        step();
        pkt_abort = 1'b0;
        out_ready = 1'b1;
        checks += 3;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL abort_valid got=%0b expected=0", out_valid); end
        if (pkt_busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%0b expected=0", pkt_busy); end
        if (sb.size() != PKT_LEN - 6) begin failures++; $display("FAIL abort_consumed got=%0d expected=%0d", PKT_LEN - sb.size(), 6); end
        sb.delete();
        run_packet();
        checks++;
        if (obs_pkt[0] !== HDR) begin failures++; $display("FAIL abort_restart got=%02h expected=aa", obs_pkt[0]); end
    endtask

    initial begin
        sensor_ok = 2'b11;
        test_reset();
        test_basic();
        test_empty();
        test_stall();
        test_drop_and_seq();
        test_snap_collision();
        test_abort();
        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
